alu_issue_arbiter: RTL
======================

# alu_issue_arbiter

Shares one `alu` instance between `NUM_REQ` requesters (issue slots of the execution stage). Each cycle it round-robin arbitrates valid requests, registers the winner's opcode/operands onto the ALU inputs, and tracks a requester tag through the ALU's `ALU_LATENCY` stages. Results land in a credit-protected result FIFO that drains over a valid/ready response port. Opcodes 0xD–0xF are flagged as errors instead of being executed.

## Interface
Parameters:
- `REG_WIDTH`, default `` `ALU_REG_WIDTH ``: operand and result width.
- `NUM_REQ`, default 4: number of requesters, ≥2. `ID_W = $clog2(NUM_REQ)`.
- `ALU_LATENCY`, default 0: register stages inside the attached ALU. Use 0 for `alu_comb` and the stage count for `alu_comb_piped`.
- `FIFO_DEPTH`, fixed = `ALU_LATENCY+3`: result FIFO entries.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid_i` in `NUM_REQ`: request valid, one bit per requester.
- `req_ready_o` out `NUM_REQ`: one-hot grant/accept.
- `req_instr_i` in `NUM_REQ*4`: opcodes, requester i at bits `[4i+3:4i]`.
- `req_a_i`, `req_b_i` in `NUM_REQ*REG_WIDTH`: operands, packed the same way.
- `req_cin_i` in `NUM_REQ`: carry-in per requester.
- `alu_instr_o` out 4, `alu_a_o`/`alu_b_o` out `REG_WIDTH`, `alu_cin_o` out 1: registered ALU inputs.
- `alu_acc_i` in `REG_WIDTH`, `alu_cout_i` in 1: ALU result and carry-out.
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: response handshake.
- `rsp_id_o` out `ID_W`, `rsp_data_o` out `REG_WIDTH`, `rsp_cout_o` out 1, `rsp_err_o` out 1: response payload.

## Operation
- **Requester contract.** Once `req_valid_i[i]` rises, payload is held stable until `req_valid_i[i]&req_ready_o[i]`. Valid must not depend on ready.
- **Credits.** `cnt` = entries in the operand register, the ALU stages and the FIFO, registered. A same-cycle pop is not credited back.
  - `can_issue = (cnt < FIFO_DEPTH)`.
- **Grant.** Round-robin. Priority starts at `last+1` mod `NUM_REQ`.
  - `req_ready_o` is one-hot among valid requesters when `can_issue`, else all-zero. It is combinational from `req_valid_i` and registered state.
  - `last` updates to the winner only on accept.
- **Issue.** On accept, the winner's instr/a/b/cin are captured into the `alu_*_o` registers and `{tag_valid=1, id}` is captured into stage 0 of the tag pipe.
  - With no accept, `alu_*_o` hold their values and stage 0 `tag_valid=0`.
- **Tag pipe.** `ALU_LATENCY` further stages, shifting every cycle. The last stage aligns with `alu_acc_i`/`alu_cout_i`.
- **Illegal opcode (0xD–0xF).**
  - It is still accepted and still occupies one slot.
  - The tag carries `err=1`.
  - The FIFO entry is written with `data=0, cout=0, err=1`.
- **Legal opcodes.** Write `data=alu_acc_i, cout=alu_cout_i, err=0`. Barrel-shift codes 9–C count as legal and return whatever the ALU produces.
- **Result FIFO.**
  - Writes happen when the aligned tag is valid; pop when `rsp_valid_o&rsp_ready_i`. Simultaneous push and pop are allowed.
  - Circular pointers wrap at `FIFO_DEPTH`.
  - Overflow is impossible by construction. An assertion flags a push to a full FIFO with no pop.
- **Response.** `rsp_valid_o = !empty`. Payload comes from the FIFO head and is stable while `rsp_valid_o&!rsp_ready_i`. Responses return in issue order.
- **Reset.** Asserting `reset` at any time:
  - discards everything in flight (tag valids, FIFO, `cnt` all go to 0);
  - sets `last=NUM_REQ-1`, so requester 0 has top priority.
  - ALU outputs are ignored until new tags arrive.

## Timing
- Reset values:
  - `req_ready_o`: 0 during reset.
  - `alu_instr_o`, `alu_a_o`, `alu_b_o`, `alu_cin_o`: 0.
  - `rsp_valid_o`, `rsp_id_o`, `rsp_data_o`, `rsp_cout_o`, `rsp_err_o`: 0.
- Accept in cycle T:
  - `alu_*_o` valid in T+1;
  - result sampled at the end of T+1+`ALU_LATENCY`;
  - `rsp_valid_o` high in T+2+`ALU_LATENCY` at the earliest.
- With `rsp_ready_i=1` held, one accept per cycle is sustained indefinitely.
- With `rsp_ready_i=0`, exactly `FIFO_DEPTH` accepts occur, then `req_ready_o=0` until pops free credits. A credit freed by a pop in cycle P is usable in P+1.

## Test plan
- **Single request, comb ALU.** Reset, then requester 2 sends ADD a=5 b=7 cin=0 at T -> `alu_a_o=5` at T+1; `rsp_valid_o` at T+2 with id=2, data=12, err=0.
- **Fairness.** All 4 requesters hold valid with `rsp_ready_i=1` -> grants 0,1,2,3,0,… one per cycle; responses return in that order.
- **Backpressure.** `ALU_LATENCY=2`, `rsp_ready_i=0`, continuous requests -> exactly 5 accepts, then `req_ready_o=0`. Raise ready -> 5 in-order responses with stable payloads, then issue resumes.
- **Illegal opcode.** Opcode 0xE from requester 1 -> response id=1, err=1, data=0, cout=0. Adjacent legal ops are unaffected.
- **Reset mid-flight.** 3 ops accepted with `ALU_LATENCY=2`, then `reset` for one cycle -> no response ever appears for them. The next request after reset goes to requester 0 when all are valid.
- **SUB with carry.** SUB a=3 b=5 cin=1, `REG_WIDTH=16` -> data=0xFFFE and the ALU's `cout` passed through unchanged.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one shared ALU, with a requester tag
// carried alongside the ALU stages and a credit-protected result FIFO on the response side.
`ifndef ALU_REG_WIDTH
`define ALU_REG_WIDTH 16
`endif

module alu_issue_arbiter #(
    parameter int  REG_WIDTH   = `ALU_REG_WIDTH,
    parameter int  NUM_REQ     = 4,
    parameter int  ALU_LATENCY = 0,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int FIFO_DEPTH  = ALU_LATENCY + 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*4-1:0]         req_instr_i,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]           req_cin_i,
    output logic [3:0]                   alu_instr_o,
    output logic [REG_WIDTH-1:0]         alu_a_o,
    output logic [REG_WIDTH-1:0]         alu_b_o,
    output logic                         alu_cin_o,
    input  logic [REG_WIDTH-1:0]         alu_acc_i,
    input  logic                         alu_cout_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic [REG_WIDTH-1:0]         rsp_data_o,
    output logic                         rsp_cout_o,
    output logic                         rsp_err_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ID_W + REG_WIDTH + 2;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ID_W-1:0]      last;
    logic [ID_W-1:0]      win;
    logic [ID_W-1:0]      idx;
    logic                 found;
    logic                 can_issue;
    logic                 accept;
    logic [NUM_REQ-1:0]   grant;
    logic [3:0]           sel_instr;
    logic [REG_WIDTH-1:0] sel_a;
    logic [REG_WIDTH-1:0] sel_b;
    logic                 sel_cin;
    logic [CNT_W-1:0]     cnt;

    logic                 tag_valid [ALU_LATENCY+1];
    logic [ID_W-1:0]      tag_id    [ALU_LATENCY+1];
    logic                 tag_err   [ALU_LATENCY+1];

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [ENT_W-1:0]     push_ent;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic                 full;

    // cnt covers operand register, ALU stages and FIFO, so a full pipe can always drain
    assign can_issue = (cnt < DEPTH_C);

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && can_issue && !reset) begin
            grant[win] = 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign accept      = |grant;

    always_comb begin
        sel_instr = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_cin   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_instr = req_instr_i[4*i +: 4];
                sel_a     = req_a_i[REG_WIDTH*i +: REG_WIDTH];
                sel_b     = req_b_i[REG_WIDTH*i +: REG_WIDTH];
                sel_cin   = req_cin_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_instr_o <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            alu_cin_o   <= 1'b0;
            last        <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            alu_instr_o <= sel_instr;
            alu_a_o     <= sel_a;
            alu_b_o     <= sel_b;
            alu_cin_o   <= sel_cin;
            last        <= win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= ALU_LATENCY; s++) begin
                tag_valid[s] <= 1'b0;
            end
        end else begin
            tag_valid[0] <= accept;
            for (int s = 1; s <= ALU_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0]  <= win;
        tag_err[0] <= (sel_instr >= 4'hD);
        for (int s = 1; s <= ALU_LATENCY; s++) begin
            tag_id[s]  <= tag_id[s-1];
            tag_err[s] <= tag_err[s-1];
        end
    end

    assign push  = tag_valid[ALU_LATENCY];
    assign empty = (fifo_cnt == '0);
    assign full  = (fifo_cnt == DEPTH_C);
    assign pop   = rsp_valid_o && rsp_ready_i;

    // illegal opcodes never forward whatever the ALU happened to produce
    assign push_ent = tag_err[ALU_LATENCY]
                    ? {tag_id[ALU_LATENCY], {REG_WIDTH{1'b0}}, 1'b0, 1'b1}
                    : {tag_id[ALU_LATENCY], alu_acc_i, alu_cout_i, 1'b0};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rsp_valid_o = !empty;
    assign {rsp_id_o, rsp_data_o, rsp_cout_o, rsp_err_o} = empty ? '0 : mem[rd_ptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule
